lfsr_seed_loader_master: RTL and testbench

// Avalon-MM initiator that programs the LFSR seed register. On a start pulse it

---
 rtl/lfsr_seed_loader_master_if.sv | 25 ++
 rtl/lfsr_seed_loader_master.sv | 203 ++++++++++++++++++++
 tb/tb_lfsr_seed_loader_master.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_seed_loader_master_if.sv
// Avalon-MM bus between the seed loader (master) and the seed register slave.
// Signals:
//   avm_address / avm_write / avm_writedata / avm_read : master -> slave
//   avm_readdata / avm_waitrequest                      : slave -> master
interface lfsr_seed_loader_master_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 2
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_read;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_writedata, avm_read,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_writedata, avm_read,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/lfsr_seed_loader_master.sv
// Seed loader: on start, writes a seed (external seed_in or internal Galois
// LFSR value) to the seed register, reads it back and flags a mismatch.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             one-cycle request, honoured in IDLE only
//   use_seed_in       1: write seed_in, 0: write internal generator value
//   seed_in           external seed, latched with start
//   busy              high from the cycle after start until DONE exits
//   done              one-cycle end-of-sequence pulse
//   error             readback mismatch or timeout, held until next start
//   timeout           watchdog abort, held until next start
//   avm               Avalon-MM master port (lfsr_seed_loader_master_if.master)
// Optional feature: define LFSR_SEED_TIMEOUT_EN to add a waitrequest watchdog
// that aborts a stalled access after TIMEOUT_CYC stalled cycles.
module lfsr_seed_loader_master #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 2,
  parameter int unsigned       SEED_ADDR    = 0,
  parameter logic [DATA_W-1:0] DEFAULT_SEED = DATA_W'(32'h3F60FF91),
  parameter logic [DATA_W-1:0] POLY         = DATA_W'(32'h80200003),
  parameter int unsigned       TIMEOUT_CYC  = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      use_seed_in,
  input  logic [DATA_W-1:0]         seed_in,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      timeout,
  lfsr_seed_loader_master_if.master avm
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              timeout_q, timeout_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] gen_q, gen_d;
  logic              used_gen_q, used_gen_d;
  logic [DATA_W-1:0] gen_step_c;
  logic              tmo_hit_c;

`ifdef LFSR_SEED_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             in_access_c;

  assign in_access_c = (state_q == S_WRITE) || (state_q == S_READ);

  // Watchdog: cleared on entry to an access, counts stalled cycles within it
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if ((state_d != state_q) && ((state_d == S_WRITE) || (state_d == S_READ))) begin
      wd_cnt_d = '0;
    end else if (in_access_c && avm.avm_waitrequest) begin
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // This stalled cycle is the TIMEOUT_CYC-th one: abort the access
  assign tmo_hit_c = in_access_c && avm.avm_waitrequest &&
                     (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo_hit_c      = 1'b0;
`endif

  // Galois step; an all-zero result would lock up, so it restarts at DEFAULT_SEED
  always_comb begin
    gen_step_c = gen_q[0] ? ((gen_q >> 1) ^ POLY) : (gen_q >> 1);
    if (gen_step_c == '0) begin
      gen_step_c = DEFAULT_SEED;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_WRITE;
      S_WRITE: begin
        if (!avm.avm_waitrequest) state_d = S_READ;
        else if (tmo_hit_c)       state_d = S_DONE;
      end
      S_READ: begin
        if (!avm.avm_waitrequest || tmo_hit_c) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; strobes follow the next state so they are registered
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    write_d    = (state_d == S_WRITE);
    read_d     = (state_d == S_READ);
    error_d    = error_q;
    timeout_d  = timeout_q;
    wdata_d    = wdata_q;
    gen_d      = gen_q;
    used_gen_d = used_gen_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wdata_d    = use_seed_in ? seed_in : gen_q;
          used_gen_d = !use_seed_in;
          error_d    = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      S_WRITE: begin
        if (tmo_hit_c) begin
          error_d   = 1'b1;
          timeout_d = 1'b1;
        end
      end
      S_READ: begin
        if (!avm.avm_waitrequest) begin
          error_d = (avm.avm_readdata != wdata_q);
        end else if (tmo_hit_c) begin
          error_d   = 1'b1;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        // Generator only advances after a completed sequence that consumed it
        if (used_gen_q && !timeout_q) begin
          gen_d = gen_step_c;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      wdata_q    <= '0;
      gen_q      <= DEFAULT_SEED;
      used_gen_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      timeout_q  <= timeout_d;
      write_q    <= write_d;
      read_q     <= read_d;
      wdata_q    <= wdata_d;
      gen_q      <= gen_d;
      used_gen_q <= used_gen_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign timeout           = timeout_q;
  assign avm.avm_address   = ADDR_W'(SEED_ADDR);
  assign avm.avm_write     = write_q;
  assign avm.avm_read      = read_q;
  assign avm.avm_writedata = wdata_q;

endmodule

// File: tb/tb_lfsr_seed_loader_master.sv
module tb_lfsr_seed_loader_master;

  localparam logic [31:0] DEF_SEED = 32'h3F60FF91;
  localparam logic [31:0] POLY     = 32'h80200003;
  localparam int          LIMIT    = 400;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        use_seed_in;
  logic [31:0] seed_in;
  logic        busy;
  logic        done;
  logic        error;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  logic [31:0] gen_model;

  lfsr_seed_loader_master_if #(.DATA_W(32), .ADDR_W(2)) bus ();

  lfsr_seed_loader_master dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .use_seed_in (use_seed_in),
    .seed_in     (seed_in),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .timeout     (timeout),
    .avm         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          done_cyc;
    int          wr_cycles;
    int          rd_cycles;
    logic [31:0] wdata;
    bit          unstable;
    bit          overlap;
    bit          busy_bad;
    bit          post_bad;
    bit          err_c1;
    bit          err;
    bit          tmo;
  } obs_t;

  typedef struct {
    bit          use_in;
    logic [31:0] seed;
    int          wr_st;
    int          rd_st;
    bit          corrupt;
    bit          extra;
    logic [31:0] exp_wdata;
    int          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference generator: one Galois step, with zero replaced by the default seed
  function automatic logic [31:0] model_step(input logic [31:0] g);
    logic [31:0] n;
    if ((g % 2) == 1) n = (g / 2) ^ POLY;
    else              n = g / 2;
    if (n == 0) n = DEF_SEED;
    return n;
  endfunction

  // Runs one sequence against a slave model with given stall counts; records what the bus did
  task automatic run_txn(input bit use_in, input logic [31:0] seed, input int wr_st,
                         input int rd_st, input bit corrupt, input bit extra, output obs_t o);
    int          wl;
    int          rl;
    logic [31:0] mem;
    o.done_cyc = 0; o.wr_cycles = 0; o.rd_cycles = 0; o.wdata = '0;
    o.unstable = 0; o.overlap = 0; o.busy_bad = 0; o.post_bad = 0;
    o.err_c1 = 0; o.err = 0; o.tmo = 0;
    wl  = wr_st;
    rl  = rd_st;
    mem = '0;
    @(negedge clk);
    start = 1'b1; use_seed_in = use_in; seed_in = seed; bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= LIMIT; k++) begin
      start = extra;
      seed_in = $urandom;
      use_seed_in = 1'($urandom_range(0, 1));
      if (bus.avm_write && bus.avm_read) o.overlap = 1;
      if (!busy) o.busy_bad = 1;
      if (k == 1) o.err_c1 = error;
      if (bus.avm_write) begin
        if (o.wr_cycles == 0) o.wdata = bus.avm_writedata;
        else if (bus.avm_writedata !== o.wdata) o.unstable = 1;
        o.wr_cycles++;
        if (wl > 0) begin bus.avm_waitrequest = 1'b1; wl--; end
        else begin bus.avm_waitrequest = 1'b0; mem = bus.avm_writedata; end
      end else if (bus.avm_read) begin
        o.rd_cycles++;
        if (rl > 0) begin
          bus.avm_waitrequest = 1'b1; rl--; bus.avm_readdata = $urandom;
        end else begin
          bus.avm_waitrequest = 1'b0;
          bus.avm_readdata = corrupt ? (mem ^ 32'h1) : mem;
        end
      end else begin
        bus.avm_waitrequest = 1'($urandom_range(0, 1));
        bus.avm_readdata = $urandom;
      end
      if (done) begin
        o.done_cyc = k; o.err = error; o.tmo = timeout;
        break;
      end
      @(negedge clk);
    end
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done || bus.avm_write || bus.avm_read) o.post_bad = 1;
    end
  endtask

  task automatic verify(input string tag, input obs_t o, input logic [31:0] ew, input int edone,
                        input bit eerr, input bit etmo, input int ewr, input int erd);
    check({tag, "_wdata"},    64'(o.wdata),     64'(ew));
    check({tag, "_done_cyc"}, 64'(o.done_cyc),  64'(edone));
    check({tag, "_error"},    64'(o.err),       64'(eerr));
    check({tag, "_timeout"},  64'(o.tmo),       64'(etmo));
    check({tag, "_wr_cyc"},   64'(o.wr_cycles), 64'(ewr));
    check({tag, "_rd_cyc"},   64'(o.rd_cycles), 64'(erd));
    check({tag, "_stable"},   64'(o.unstable),  64'(0));
    check({tag, "_overlap"},  64'(o.overlap),   64'(0));
    check({tag, "_busy"},     64'(o.busy_bad),  64'(0));
    check({tag, "_post"},     64'(o.post_bad),  64'(0));
    check({tag, "_err_clr"},  64'(o.err_c1),    64'(0));
  endtask

  initial begin
    obs_t        o;
    bit          seen;
    bit          r_use;
    logic [31:0] r_seed;
    int          r_wr;
    int          r_rd;
    bit          r_cor;
    bit          r_ext;
    logic [31:0] ew;

    // use_in, seed, wr_st, rd_st, corrupt, extra, exp_wdata, exp_done, exp_err
    vecs[0] = '{1'b0, 32'h0,        0, 0, 1'b0, 1'b0, 32'h3F60FF91, 3, 1'b0};
    vecs[1] = '{1'b1, 32'hDEADBEEF, 3, 0, 1'b0, 1'b0, 32'hDEADBEEF, 6, 1'b0};
    vecs[2] = '{1'b0, 32'h0,        0, 0, 1'b0, 1'b0, 32'h9F907FCB, 3, 1'b0};
    vecs[3] = '{1'b1, 32'hDEADBEEF, 0, 2, 1'b1, 1'b0, 32'hDEADBEEF, 5, 1'b1};
    vecs[4] = '{1'b1, 32'h12345678, 1, 1, 1'b0, 1'b1, 32'h12345678, 5, 1'b0};
    vecs[5] = '{1'b0, 32'h0,        2, 1, 1'b0, 1'b0, 32'hCFE83FE6, 6, 1'b0};

    reset_n = 1'b0; start = 1'b0; use_seed_in = 1'b0; seed_in = '0;
    bus.avm_readdata = '0; bus.avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",    64'(busy),              64'(0));
    check("rst_done",    64'(done),              64'(0));
    check("rst_error",   64'(error),             64'(0));
    check("rst_timeout", 64'(timeout),           64'(0));
    check("rst_write",   64'(bus.avm_write),     64'(0));
    check("rst_read",    64'(bus.avm_read),      64'(0));
    check("rst_wdata",   64'(bus.avm_writedata), 64'(0));
    check("rst_addr",    64'(bus.avm_address),   64'(0));
    reset_n = 1'b1;
    gen_model = DEF_SEED;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].use_in, vecs[i].seed, vecs[i].wr_st, vecs[i].rd_st,
              vecs[i].corrupt, vecs[i].extra, o);
      verify($sformatf("vec%0d", i), o, vecs[i].exp_wdata, vecs[i].exp_done, vecs[i].exp_err,
             1'b0, vecs[i].wr_st + 1, vecs[i].rd_st + 1);
      if (!vecs[i].use_in) gen_model = model_step(gen_model);
      if (vecs[i].exp_err) begin
        repeat (3) @(negedge clk);
        check($sformatf("vec%0d_err_hold", i), 64'(error), 64'(1));
      end
    end

    // Reset during a stalled read
    @(negedge clk);
    start = 1'b1; use_seed_in = 1'b0;
    @(negedge clk);
    start = 1'b0; bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    check("rstmid_read_active", 64'(bus.avm_read), 64'(1));
    reset_n = 1'b0;
    #1;
    check("rstmid_read_drop", 64'(bus.avm_read),  64'(0));
    check("rstmid_busy_drop", 64'(busy),          64'(0));
    check("rstmid_write",     64'(bus.avm_write), 64'(0));
    @(negedge clk);
    reset_n = 1'b1; bus.avm_waitrequest = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("rstmid_no_done", 64'(seen), 64'(0));
    gen_model = DEF_SEED;
    run_txn(1'b0, 32'h0, 0, 0, 1'b0, 1'b0, o);
    verify("rstmid_gen", o, DEF_SEED, 3, 1'b0, 1'b0, 1, 1);
    gen_model = model_step(gen_model);

    // Randomized sequences against the reference model
    for (int n = 0; n < 30; n++) begin
      r_use  = 1'($urandom_range(0, 1));
      r_seed = $urandom;
      r_wr   = int'($urandom_range(0, 4));
      r_rd   = int'($urandom_range(0, 4));
      r_cor  = ($urandom_range(0, 3) == 0);
      r_ext  = 1'($urandom_range(0, 1));
      ew     = r_use ? r_seed : gen_model;
      run_txn(r_use, r_seed, r_wr, r_rd, r_cor, r_ext, o);
      verify($sformatf("rnd%0d", n), o, ew, 3 + r_wr + r_rd, r_cor, 1'b0, r_wr + 1, r_rd + 1);
      if (!r_use) gen_model = model_step(gen_model);
    end

`ifdef LFSR_SEED_TIMEOUT_EN
    // Permanently stalled write aborts after 255 stalled cycles
    run_txn(1'b0, 32'h0, 100000, 0, 1'b0, 1'b0, o);
    verify("tmo_write", o, gen_model, 256, 1'b1, 1'b1, 255, 0);
    check("tmo_hold", 64'(timeout), 64'(1));
    run_txn(1'b0, 32'h0, 0, 0, 1'b0, 1'b0, o);
    verify("tmo_gen_kept", o, gen_model, 3, 1'b0, 1'b0, 1, 1);
    gen_model = model_step(gen_model);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
